alu_seq: RTL and testbench

Sequential 8-bit ALU that consumes the B operand selected by the B-operand mux and the A operand from the register file, and produces a registered result plus flags for write-back. Single-cycle logic and add/subtract ops complete in one cycle. Shifts are iterative, one bit per cycle, and multiply is 8-cycle shift-add. A start/busy/done handshake lets the controller stall while a multi-cycle op runs.

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic, iterative shifts (one bit per
// cycle) and an 8-step shift-add multiply behind a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [0:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH:0]     add_s, sub_s;
  // One iteration of the multi-cycle datapath, evaluated on latched copies
  logic [WIDTH-1:0]   sh_step;
  logic               sh_out;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  // Completion write port
  logic               wr;
  logic [WIDTH-1:0]   wr_res;
  logic               wr_carry;

  // Arithmetic for this cycle: immediate ops and one iterative step.
  always_comb begin
    add_s     = {1'b0, a} + {1'b0, b};
    sub_s     = {1'b0, a} - {1'b0, b};  // top bit is the borrow
    sh_step   = (op_q == OP_SHL) ? (sh_q << 1) : (sh_q >> 1);
    sh_out    = (op_q == OP_SHL) ? sh_q[WIDTH-1] : sh_q[0];
    // Multiplier sits in the low half and is consumed LSB first
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
  end

  // Next-state: accept in IDLE, iterate in EXEC, write result/flags on completion.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    wr       = 1'b0;
    wr_res   = '0;
    wr_carry = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          unique case (op)
            OP_ADD: begin wr = 1'b1; wr_res = add_s[WIDTH-1:0]; wr_carry = add_s[WIDTH]; end
            OP_SUB: begin wr = 1'b1; wr_res = sub_s[WIDTH-1:0]; wr_carry = sub_s[WIDTH]; end
            OP_AND: begin wr = 1'b1; wr_res = a & b; end
            OP_OR:  begin wr = 1'b1; wr_res = a | b; end
            OP_XOR: begin wr = 1'b1; wr_res = a ^ b; end
            OP_SHL, OP_SHR: begin
              if (b[2:0] == 3'd0) begin
                wr     = 1'b1;
                wr_res = a;
              end else begin
                sh_d    = a;
                cnt_d   = CntW'(b[2:0]);
                state_d = EXEC;
              end
            end
            OP_MUL: begin
              prod_d  = {{WIDTH{1'b0}}, b};
              mcand_d = a;
              cnt_d   = CntW'(WIDTH);
              state_d = EXEC;
            end
          endcase
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          prod_d = prod_step;
        end else begin
          sh_d = sh_step;
        end
        if (cnt_q == CntW'(1)) begin
          wr      = 1'b1;
          state_d = IDLE;
          if (op_q == OP_MUL) begin
            wr_res   = prod_step[WIDTH-1:0];
            wr_carry = |prod_step[2*WIDTH-1:WIDTH];
          end else begin
            wr_res   = sh_step;
            wr_carry = sh_out;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr) begin
      result_d = wr_res;
      carry_d  = wr_carry;
      zero_d   = (wr_res == '0);
      neg_d    = wr_res[WIDTH-1];
      done_d   = 1'b1;
    end
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = neg_q;
  assign done     = done_q;
  assign busy     = (state_q == EXEC);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model expectations, monitor pops
// them on each done pulse and also checks outputs hold between completions.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic [7:0] result;
  logic       zero, carry, negative, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // {result, zero, carry, negative}
  logic [10:0] sb[$];

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model from the arithmetic rules, plain integer math
  function automatic logic [10:0] model(input logic [2:0] o, input int x, input int y);
    int r, c, n, p;
    n = y % 8;
    c = 0;
    case (o)
      3'd0: begin p = x + y; r = p % 256; c = (p > 255) ? 1 : 0; end
      3'd1: begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin p = x * (2 ** n); r = p % 256; c = (n > 0) ? (p / 256) % 2 : 0; end
      3'd6: begin r = x / (2 ** n); c = (n > 0) ? (x / (2 ** (n - 1))) % 2 : 0; end
      default: begin p = x * y; r = p % 256; c = (p > 255) ? 1 : 0; end
    endcase
    return {r[7:0], (r == 0), c[0], (r >= 128)};
  endfunction

  function automatic int latency(input logic [2:0] o, input int y);
    if (o == 3'd7) return 8;
    if (o == 3'd5 || o == 3'd6) return y % 8;
    return 0;
  endfunction

  // Issue one op and track its handshake; poke>0 pulses an ADD start on that
  // EXEC cycle, which must be ignored.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input int poke);
    int lat, exp_lat;
    exp_lat = latency(o, int'(y));
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(model(o, int'(x), int'(y)));
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);  // latched copies must be used
    lat = 0;
    @(negedge clk);
    chk("busy_after_accept", busy, (exp_lat > 0));
    while (!done && lat < 20) begin
      if (poke > 0 && lat == poke - 1) begin
        op = 3'd0; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("busy_in_done", busy, 1'b0);
  endtask

  // Monitor: compare at each done, otherwise outputs must hold
  logic [10:0] last;
  always @(negedge clk) begin
    if (rst) begin
      last = {result, zero, carry, negative};
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        chk("flags_result", {result, zero, carry, negative}, sb.pop_front());
      end
      last = {result, zero, carry, negative};
    end else begin
      chk("hold", {result, zero, carry, negative}, last);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ro;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 8'h00);
    chk("rst_zero", zero, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_negative", negative, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    issue(3'd0, 8'd5, 8'd9, 0);
    issue(3'd1, 8'd5, 8'd9, 0);
    issue(3'd1, 8'd9, 8'd9, 0);
    issue(3'd5, 8'h81, 8'd1, 0);
    issue(3'd5, 8'h81, 8'd0, 0);
    issue(3'd6, 8'h81, 8'd7, 0);
    issue(3'd7, 8'h10, 8'h20, 0);
    issue(3'd7, 8'd12, 8'd11, 0);
    issue(3'd7, 8'hff, 8'hff, 3);  // ignored ADD start mid-MUL
    repeat (4) @(negedge clk);    // any spurious done is flagged by the monitor

    // Reset on the 4th cycle of a MUL
    op = 3'd7; a = 8'd200; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_result", result, 8'h00);
    chk("abort_flags", {zero, carry, negative}, 3'b000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    rst = 1'b0;
    issue(3'd0, 8'd5, 8'd9, 0);

    // Random traffic, back-to-back from the done cycle
    for (int i = 0; i < 250; i++) begin
      ro = 3'($urandom_range(0, 7));
      issue(ro, 8'($urandom), 8'($urandom), 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
